// File: rtl/periph_rx_handshake.sv
// Peripheral-side receiver for the CPU send/ack four-phase handshake, buffering words in a show-ahead FIFO.
// Optional feature: define PERIPH_RX_SYNC_EN to pass send through a 2-flop synchronizer on clk2.
module periph_rx_handshake #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dado,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_send_i;
    logic                w_full;
    logic                w_wr;
    logic                w_pop;
    logic                w_stall;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

`ifdef PERIPH_RX_SYNC_EN
    logic [1:0]          r_send_sync;

    // Two-flop synchronizer for a send strobe coming from an unrelated clock domain
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_send_sync <= 2'b00;
        end else begin
            r_send_sync <= {r_send_sync[0], send};
        end
    end

    assign w_send_i = r_send_sync[1];
`else
    assign w_send_i = send;
`endif

    // Full is taken from the registered count, so a same-cycle pop cannot admit a write
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = rd_en && (r_count != {CNT_W{1'b0}});

    // Handshake state register
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one capture per handshake, release when send falls
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_send_i && !w_full) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (w_send_i) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: FIFO write strobe and stall indication
    always_comb begin
        w_wr    = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_send_i) begin
                    if (w_full) begin
                        w_stall = 1'b1;
                    end else begin
                        w_wr = 1'b1;
                    end
                end else begin
                    w_wr = 1'b0;
                end
            end
            ST_ACK:  w_wr = 1'b0;
            default: w_wr = 1'b0;
        endcase
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk2) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dado;
        end
    end

    assign ack      = (r_state == ST_ACK);
    assign rd_valid = (r_count != {CNT_W{1'b0}});
    assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
    assign count    = r_count;
    assign stall    = w_stall;

endmodule

// File: tb/tb_periph_rx_handshake.sv
// Directed, scoreboard-based bench for periph_rx_handshake (DATA_W=2, DEPTH=4).
module tb_periph_rx_handshake;

`ifdef PERIPH_RX_SYNC_EN
    localparam int SLAT = 3;
`else
    localparam int SLAT = 1;
`endif

    logic       clk2 = 1'b0;
    logic       rst;
    logic       send;
    logic [1:0] dado;
    logic       ack;
    logic       rd_en;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       stall;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb_q [$];
    logic [1:0] exp_v;

    periph_rx_handshake #(.DATA_W(2), .DEPTH(4)) dut (
        .clk2(clk2), .rst(rst), .send(send), .dado(dado), .ack(ack),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .stall(stall)
    );

    always #5 clk2 = ~clk2;

    task automatic step(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full four-phase handshake on a non-full FIFO
    task automatic handshake(input logic [1:0] d);
        send = 1'b1;
        dado = d;
        sb_q.push_back(d);
        step(SLAT);
        check("hs_ack_rise", ack, 1);
        send = 1'b0;
        step(SLAT);
        check("hs_ack_fall", ack, 0);
    endtask

    // Pop one word and compare it against the scoreboard head
    task automatic pop_check(input string tag);
        exp_v = sb_q.pop_front();
        check(tag, rd_data, exp_v);
        check("pop_valid", rd_valid, 1);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; send = 1'b0; dado = 2'b00; rd_en = 1'b0;
        step(2);
        rst = 1'b0;
        step(5);
        check("rst_ack", ack, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_data", rd_data, 0);
        check("rst_stall", stall, 0);

        // Single handshake
        handshake(2'b10);
        check("one_count", count, 1);
        check("one_data", rd_data, 2'b10);
        pop_check("one_pop");
        check("one_empty", count, 0);

        // Fill to full, then fifth send stalls
        handshake(2'b00);
        handshake(2'b01);
        handshake(2'b10);
        handshake(2'b11);
        send = 1'b1;
        dado = 2'b01;
        step(SLAT);
        check("full_stall", stall, 1);
        check("full_ack", ack, 0);
        check("full_count", count, 4);
        exp_v = sb_q.pop_front();
        check("full_head", rd_data, exp_v);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("pop_nowrite_count", count, 3);
        check("pop_nowrite_ack", ack, 0);
        check("unstall", stall, 0);
        step(1);
        sb_q.push_back(2'b01);
        check("late_write_ack", ack, 1);
        check("late_write_count", count, 4);
        send = 1'b0;
        step(SLAT);
        check("late_ack_fall", ack, 0);
        for (int i = 0; i < 4; i++) pop_check("drain_full");
        check("drain_count", count, 0);

        // Simultaneous write and pop at count 2
        handshake(2'b11);
        handshake(2'b10);
        send = 1'b1;
        dado = 2'b01;
        step(SLAT - 1);
        exp_v = sb_q.pop_front();
        check("sim_head", rd_data, exp_v);
        sb_q.push_back(2'b01);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("sim_count", count, 2);
        check("sim_ack", ack, 1);
        send = 1'b0;
        step(SLAT);
        pop_check("sim_pop1");
        pop_check("sim_pop2");
        check("sim_empty", count, 0);

        // Wrap-around with rd_en held while empty
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            step(2);
            rd_en = 1'b0;
            check("empty_pop_count", count, 0);
            check("empty_pop_data", rd_data, 0);
            handshake(2'(i * 3 + 1));
            check("wrap_count", count, 1);
            pop_check("wrap_pop");
        end

        // Reset while in ACK with three words stored
        handshake(2'b01);
        handshake(2'b11);
        send = 1'b1;
        dado = 2'b10;
        step(SLAT);
        check("pre_rst_ack", ack, 1);
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        step(1);
        sb_q.delete();
        check("mid_rst_ack", ack, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", rd_valid, 0);
        rst = 1'b0;
        dado = 2'b11;
        sb_q.push_back(2'b11);
        step(SLAT);
        check("post_rst_ack", ack, 1);
        check("post_rst_count", count, 1);
        send = 1'b0;
        step(SLAT);
        pop_check("post_rst_pop");
        check("final_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
